izh_neuron_scheduler: RTL

Time-multiplexes one Izhikevich neuron update engine across N_NEURONS neurons. Holds per-neuron membrane (v), recovery (u) and input-current (I) state in internal registers. On each start pulse it runs one simulation timestep: it sequences every neuron through the shared engine, writes the results back, and collects spikes into a vector. It sits between the stimulus/config logic and the single neuron datapath.

---
 rtl/izh_neuron_scheduler.sv | 121 ++++++++++++
 1 files changed

// File: rtl/izh_neuron_scheduler.sv
// Sequences N_NEURONS neurons through one shared Izhikevich engine per timestep.
// Define SPIKE_CNT_EN to build the saturating total-spike counter on spike_cnt.
module izh_neuron_scheduler #(
  parameter int N_NEURONS = 8,
  parameter int W         = 20,
  parameter int IDX_W     = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 cfg_we,
  input  logic [IDX_W-1:0]     cfg_addr,
  input  logic [W-1:0]         cfg_i,
  output logic                 eng_go,
  output logic [W-1:0]         eng_v,
  output logic [W-1:0]         eng_u,
  output logic [W-1:0]         eng_i,
  input  logic                 eng_done,
  input  logic [W-1:0]         eng_v_out,
  input  logic [W-1:0]         eng_u_out,
  input  logic                 eng_spike,
  output logic                 busy,
  output logic                 done,
  output logic [N_NEURONS-1:0] spike_vec,
  output logic [15:0]          step_count,
  output logic [15:0]          spike_cnt
);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, WB, FIN} state_t;

  // Q4.16 reset values: v = -0.5, u = -0.2
  localparam logic [W-1:0] V_RST = W'(-32'sd32768);
  localparam logic [W-1:0] U_RST = W'(-32'sd13107);

  state_t           state;
  state_t           state_nx;
  logic [W-1:0]     v_mem [N_NEURONS];
  logic [W-1:0]     u_mem [N_NEURONS];
  logic [W-1:0]     i_mem [N_NEURONS];
  logic [IDX_W-1:0] idx;
  logic [15:0]      step_q;
  logic             last;

  assign last       = (idx == IDX_W'(N_NEURONS - 1));
  assign busy       = (state != IDLE);
  assign step_count = step_q;
  assign eng_v      = v_mem[idx];
  assign eng_u      = u_mem[idx];
  assign eng_i      = i_mem[idx];

  always_comb begin
    state_nx = state;
    eng_go   = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = LOAD;
      LOAD: begin
        eng_go   = 1'b1;
        state_nx = WAIT;
      end
      WAIT: if (eng_done) state_nx = WB;
      WB:   state_nx = last ? FIN : LOAD;
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      spike_vec <= '0;
      step_q    <= '0;
      for (int unsigned n = 0; n < N_NEURONS; n++) begin
        v_mem[n] <= V_RST;
        u_mem[n] <= U_RST;
        i_mem[n] <= '0;
      end
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          // Write lands in the same cycle start is seen, so LOAD reads the new I.
          if (cfg_we && (32'(cfg_addr) < N_NEURONS)) i_mem[cfg_addr] <= cfg_i;
          if (start) begin
            spike_vec <= '0;
            idx       <= '0;
          end
        end
        WB: begin
          v_mem[idx]     <= eng_v_out;
          u_mem[idx]     <= eng_u_out;
          spike_vec[idx] <= eng_spike;
          idx            <= last ? '0 : idx + 1'b1;
        end
        FIN:     step_q <= step_q + 16'd1;
        default: ;
      endcase
    end
  end

`ifdef SPIKE_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (state == WB && eng_spike && cnt_q != '1) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign spike_cnt = cnt_q;
`else
  assign spike_cnt = '0;
`endif

endmodule
